mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_mem_pkg.sv | 36 +++
 rtl/rr_arbiter2.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types for the unified-memory port arbiter:
//   arb_mode_e  - arbitration policy (fixed data-priority or round-robin)
//   arb_state_e - arbiter FSM states
//   port_e      - identifies the requesting core port (fetch or data)
// Also holds the conflict-resolution helper used by rr_arbiter2.
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    // Winner of a simultaneous request. Fixed mode always favours the data
    // port; round-robin favours whichever port did not win last time.
    function automatic logic conflict_pick_dm(input arb_mode_e mode,
                                              input port_e     last);
        return (mode == ARB_FIXED) || (last == PORT_IF);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input grant generator with a last-winner register.
//   clk_i      : clock
//   reset_i    : asynchronous active-low reset (last winner -> IF)
//   en_i       : grants may only be issued while high (arbiter idle)
//   req_if_i   : fetch port request
//   req_dm_i   : data port request
//   gnt_if_o   : fetch grant (combinational)
//   gnt_dm_o   : data grant (combinational)
// At most one grant is ever high. The last-winner register is updated on
// every grant, so in round-robin mode the port that lost the previous
// arbitration (or did not take part in it) wins the next conflict.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import riscv_mem_pkg::*;
#(
    parameter arb_mode_e MODE = ARB_FIXED
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic req_if_i,
    input  logic req_dm_i,
    output logic gnt_if_o,
    output logic gnt_dm_o
);

    port_e last_q;
    port_e last_d;

    always_comb begin
        gnt_if_o = 1'b0;
        gnt_dm_o = 1'b0;
        if (en_i) begin
            if (req_if_i && req_dm_i) begin
                if (conflict_pick_dm(MODE, last_q)) begin
                    gnt_dm_o = 1'b1;
                end else begin
                    gnt_if_o = 1'b1;
                end
            end else begin
                gnt_if_o = req_if_i;
                gnt_dm_o = req_dm_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_dm_o) begin
            last_d = PORT_DM;
        end else if (gnt_if_o) begin
            last_d = PORT_IF;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-outstanding unified memory port between the core's
// instruction-fetch (IF) and load/store (DM) ports.
//
// Parameter
//   ARB_MODE     : ARB_FIXED (DM always wins a conflict) or ARB_RR
// Ports
//   clk_i, reset_i                 : clock, asynchronous active-low reset
//   if_req_i, if_addr_i            : fetch request (held until granted)
//   if_gnt_o                       : fetch accepted this cycle
//   if_rvalid_o, if_rdata_o        : fetch data, one-cycle pulse
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                     : load/store request (held until granted)
//   dm_gnt_o                       : load/store accepted this cycle
//   dm_rvalid_o, dm_rdata_o        : load data / store done (data 0 for stores)
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                    : registered command to memory
//   mem_ready_i, mem_rdata_i       : memory completion and read data
//   stall_o                        : core must hold PC and pipeline state
//
// Timing: a grant is issued combinationally in IDLE; the command is
// registered and held for k BUSY cycles until mem_ready_i; the response
// pulses one cycle after mem_ready_i, in the next IDLE cycle, where a new
// grant may already be issued.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter arb_mode_e ARB_MODE = ARB_FIXED
) (
    input  logic            clk_i,
    input  logic            reset_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ready_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            stall_o
);

    arb_state_e      state_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            if_rvalid_q;
    logic            dm_rvalid_q;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] dm_rdata_q;

    logic            arb_en;
    logic            if_gnt;
    logic            dm_gnt;

    // Grants are combinational, so they are additionally gated by reset_i
    // to keep them low while reset is asserted even if requests are high.
    assign arb_en = (state_q == IDLE) && reset_i;

    rr_arbiter2 #(
        .MODE (ARB_MODE)
    ) u_rr_arbiter2 (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (arb_en),
        .req_if_i (if_req_i),
        .req_dm_i (dm_req_i),
        .gnt_if_o (if_gnt),
        .gnt_dm_o (dm_gnt)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            // Response strobes are single-cycle; the data registers keep
            // their value until the next response on the same port.
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // mem_ready_i is deliberately not looked at here.
                    if (dm_gnt) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                    end else if (if_gnt) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready_i) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata_i;
                    end
                end
                BUSY_DM: begin
                    if (mem_ready_i) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        dm_rvalid_q <= 1'b1;
                        // Stores return zero rather than whatever the bus shows.
                        dm_rdata_q  <= mem_we_q ? '0 : mem_rdata_i;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt_o    = if_gnt;
    assign dm_gnt_o    = dm_gnt;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Stall while a transaction is outstanding or while any request is
    // left waiting this cycle; forced low during reset.
    assign stall_o = reset_i &&
                     ((state_q != IDLE) ||
                      (if_req_i && !if_gnt) ||
                      (dm_req_i && !dm_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    // Round-robin instance (main checks)
    logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
    logic [31:0] if_rdata_o, dm_rdata_o;
    logic        mem_req_o, mem_we_o, stall_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    // Fixed-priority instance sharing the same inputs
    logic        f_if_gnt_o, f_if_rvalid_o, f_dm_gnt_o, f_dm_rvalid_o;
    logic [31:0] f_if_rdata_o, f_dm_rdata_o;
    logic        f_mem_req_o, f_mem_we_o, f_stall_o;
    logic [31:0] f_mem_addr_o, f_mem_wdata_o;

    mem_port_arbiter #(.ARB_MODE(ARB_RR)) dut_rr (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
    );

    mem_port_arbiter #(.ARB_MODE(ARB_FIXED)) dut_fx (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(f_if_gnt_o),
        .if_rvalid_o(f_if_rvalid_o), .if_rdata_o(f_if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(f_dm_gnt_o),
        .dm_rvalid_o(f_dm_rvalid_o), .dm_rdata_o(f_dm_rdata_o),
        .mem_req_o(f_mem_req_o), .mem_we_o(f_mem_we_o), .mem_addr_o(f_mem_addr_o),
        .mem_wdata_o(f_mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(f_stall_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state for the random phase
    bit          m_busy;
    bit          m_owner_dm;
    bit          m_last_dm;
    int          m_cnt;
    int          m_k;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    bit          m_rv_if, m_rv_dm;
    logic [31:0] m_rd_if, m_rd_dm;
    bit          e_if_gnt, e_dm_gnt, e_stall;
    bit          if_drop, dm_drop;
    bit          exp_rr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ready_i = 1'b0;
        nxt();
        nxt();
        reset_i = 1'b1;
    endtask

    // One isolated transaction from IDLE; k BUSY cycles, ready on the last.
    task automatic run_txn(input string tag, input bit is_dm, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int k,
                           input logic [31:0] exp_rdata);
        if (is_dm) begin
            dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        mem_ready_i = 1'b0;
        smp();
        chk1({tag, ".if_gnt"}, if_gnt_o, !is_dm);
        chk1({tag, ".dm_gnt"}, dm_gnt_o, is_dm);
        chk1({tag, ".stall0"}, stall_o, 1'b0);
        nxt();
        if_req_i = 1'b0; dm_req_i = 1'b0;
        for (int c = 1; c <= k; c++) begin
            mem_ready_i = (c == k);
            mem_rdata_i = (c == k) ? rdata : 32'hBAD0_0000 + c;
            smp();
            chk1 ({tag, ".mem_req"},   mem_req_o, 1'b1);
            chk32({tag, ".mem_addr"},  mem_addr_o, addr);
            chk1 ({tag, ".mem_we"},    mem_we_o, is_dm && we);
            chk32({tag, ".mem_wdata"}, mem_wdata_o, is_dm ? wdata : 32'h0);
            chk1 ({tag, ".stall_busy"}, stall_o, 1'b1);
            chk1 ({tag, ".no_gnt"},    if_gnt_o | dm_gnt_o, 1'b0);
            chk1 ({tag, ".early_rv"},  if_rvalid_o | dm_rvalid_o, 1'b0);
            nxt();
        end
        mem_ready_i = 1'b0;
        smp();
        chk1 ({tag, ".if_rvalid"}, if_rvalid_o, !is_dm);
        chk1 ({tag, ".dm_rvalid"}, dm_rvalid_o, is_dm);
        chk32({tag, ".rdata"}, is_dm ? dm_rdata_o : if_rdata_o, exp_rdata);
        chk1 ({tag, ".mem_req_idle"}, mem_req_o, 1'b0);
        nxt();
        smp();
        chk1 ({tag, ".rv_drop"}, if_rvalid_o | dm_rvalid_o, 1'b0);
        chk32({tag, ".rdata_hold"}, is_dm ? dm_rdata_o : if_rdata_o, exp_rdata);
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        nxt();

        // Reset state, with requests and ready asserted
        if_req_i = 1'b1; dm_req_i = 1'b1; mem_ready_i = 1'b1;
        smp();
        chk1 ("rst.if_gnt",  if_gnt_o | f_if_gnt_o, 1'b0);
        chk1 ("rst.dm_gnt",  dm_gnt_o | f_dm_gnt_o, 1'b0);
        chk1 ("rst.stall",   stall_o | f_stall_o, 1'b0);
        chk1 ("rst.mem_req", mem_req_o | f_mem_req_o, 1'b0);
        chk1 ("rst.mem_we",  mem_we_o | f_mem_we_o, 1'b0);
        chk1 ("rst.rvalid",  if_rvalid_o | dm_rvalid_o | f_if_rvalid_o | f_dm_rvalid_o, 1'b0);
        chk32("rst.addr",    mem_addr_o | f_mem_addr_o, 32'h0);
        chk32("rst.wdata",   mem_wdata_o | f_mem_wdata_o, 32'h0);
        chk32("rst.rdata",   if_rdata_o | dm_rdata_o | f_if_rdata_o | f_dm_rdata_o, 32'h0);
        nxt();
        if_req_i = 1'b0; dm_req_i = 1'b0; mem_ready_i = 1'b0;
        reset_i = 1'b1;
        nxt();

        // IF-only read, k=2: gnt at cycle 0, rvalid at cycle 3
        run_txn("if_read", 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0050_0093, 2, 32'h0050_0093);
        // Load to make dm_rdata non-zero, then a store that must return 0
        run_txn("dm_load", 1'b1, 1'b0, 32'h0000_0200, 32'h5555_5555, 32'hCAFE_0001, 1, 32'hCAFE_0001);
        run_txn("dm_store", 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 3, 32'h0);

        // Conflicts: RR -> DM, IF, DM, IF; FIXED -> DM x4, back-to-back (k=1)
        do_reset();
        if_req_i = 1'b1; if_addr_i = 32'h40;
        dm_req_i = 1'b1; dm_addr_i = 32'h80; dm_we_i = 1'b0; dm_wdata_i = 32'h0;
        for (int t = 0; t < 4; t++) begin
            mem_ready_i = 1'b0;
            smp();
            chk1("rr.dm_gnt", dm_gnt_o, exp_rr[t]);
            chk1("rr.if_gnt", if_gnt_o, !exp_rr[t]);
            chk1("fx.dm_gnt", f_dm_gnt_o, 1'b1);
            chk1("fx.if_gnt", f_if_gnt_o, 1'b0);
            if (t > 0) begin
                chk1("rr.prev_dm_rv", dm_rvalid_o, exp_rr[t-1]);
                chk1("rr.prev_if_rv", if_rvalid_o, !exp_rr[t-1]);
            end
            nxt();
            mem_ready_i = 1'b1; mem_rdata_i = 32'h100 + t;
            smp();
            chk32("rr.mem_addr", mem_addr_o, exp_rr[t] ? 32'h80 : 32'h40);
            chk1 ("rr.no_gnt_ready", if_gnt_o | dm_gnt_o, 1'b0);
            nxt();
        end
        if_req_i = 1'b0; dm_req_i = 1'b0; mem_ready_i = 1'b0;
        smp();
        chk1 ("rr.last_if_rv", if_rvalid_o, 1'b1);
        chk32("rr.last_if_rd", if_rdata_o, 32'h103);
        chk32("fx.last_dm_rd", f_dm_rdata_o, 32'h103);
        nxt();

        // DM request raised in the ready cycle of an IF transaction
        if_req_i = 1'b1; if_addr_i = 32'h20;
        smp();
        chk1("late.if_gnt", if_gnt_o, 1'b1);
        nxt();
        if_req_i = 1'b0; mem_ready_i = 1'b0;
        nxt();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
        smp();
        chk1("late.no_dm_gnt", dm_gnt_o, 1'b0);
        chk1("late.no_if_gnt", if_gnt_o, 1'b0);
        chk1("late.stall", stall_o, 1'b1);
        nxt();
        mem_ready_i = 1'b0;
        smp();
        chk1 ("late.dm_gnt", dm_gnt_o, 1'b1);
        chk1 ("late.if_rv", if_rvalid_o, 1'b1);
        chk32("late.if_rd", if_rdata_o, 32'h0000_0013);
        nxt();
        dm_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h7;
        smp();
        chk32("late.mem_addr", mem_addr_o, 32'h300);
        nxt();
        mem_ready_i = 1'b0;
        smp();
        chk1 ("late.dm_rv", dm_rvalid_o, 1'b1);
        chk32("late.dm_rd", dm_rdata_o, 32'h7);
        nxt();

        // Reset asserted mid BUSY_DM
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h400;
        smp();
        chk1("abort.gnt", dm_gnt_o, 1'b1);
        nxt();
        dm_req_i = 1'b0;
        smp();
        chk1("abort.busy", mem_req_o, 1'b1);
        reset_i = 1'b0;
        #1;
        chk1 ("abort.mem_req", mem_req_o, 1'b0);
        chk1 ("abort.stall", stall_o, 1'b0);
        chk32("abort.addr", mem_addr_o, 32'h0);
        nxt();
        mem_ready_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        smp();
        chk1("abort.no_rv_rst", dm_rvalid_o, 1'b0);
        nxt();
        reset_i = 1'b1; mem_ready_i = 1'b0;
        smp();
        chk1 ("abort.no_rv", dm_rvalid_o, 1'b0);
        chk1 ("abort.idle_req", mem_req_o, 1'b0);
        chk1 ("abort.idle_stall", stall_o, 1'b0);
        chk32("abort.rdata", dm_rdata_o, 32'h0);
        nxt();
        if_req_i = 1'b1; if_addr_i = 32'h44;
        smp();
        chk1("abort.idle_gnt", if_gnt_o, 1'b1);
        nxt();
        if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h11;
        nxt();
        mem_ready_i = 1'b0;
        nxt();

        // mem_ready_i pulsed while IDLE
        for (int c = 0; c < 3; c++) begin
            mem_ready_i = 1'b1; mem_rdata_i = $urandom;
            smp();
            chk1("idle_rdy.rv", if_rvalid_o | dm_rvalid_o, 1'b0);
            chk1("idle_rdy.mem_req", mem_req_o, 1'b0);
            chk1("idle_rdy.stall", stall_o, 1'b0);
            nxt();
        end
        mem_ready_i = 1'b0;
        smp();
        chk1 ("idle_rdy.rv_after", if_rvalid_o | dm_rvalid_o, 1'b0);
        chk32("idle_rdy.if_rd_hold", if_rdata_o, 32'h11);
        nxt();
        run_txn("idle_rdy.dm", 1'b1, 1'b0, 32'h500, 32'h0, 32'h0A0B_0C0D, 1, 32'h0A0B_0C0D);

        // Randomized traffic against the reference model
        do_reset();
        m_busy = 1'b0; m_last_dm = 1'b0; m_rv_if = 1'b0; m_rv_dm = 1'b0;
        m_rd_if = '0; m_rd_dm = '0; m_cnt = 0; m_k = 1; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_owner_dm = 1'b0;
        if_drop = 1'b0; dm_drop = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (if_drop) begin
                if_req_i = 1'b0; if_drop = 1'b0;
            end else if (!if_req_i && ($urandom_range(0, 2) == 0)) begin
                if_req_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (dm_drop) begin
                dm_req_i = 1'b0; dm_drop = 1'b0;
            end else if (!dm_req_i && ($urandom_range(0, 2) == 0)) begin
                dm_req_i = 1'b1; dm_we_i = 1'($urandom_range(0, 1));
                dm_addr_i = $urandom; dm_wdata_i = $urandom;
            end
            mem_rdata_i = $urandom;
            mem_ready_i = m_busy ? (m_cnt == m_k) : ($urandom_range(0, 3) == 0);

            e_if_gnt = 1'b0; e_dm_gnt = 1'b0;
            if (!m_busy) begin
                if (if_req_i && dm_req_i) begin
                    e_dm_gnt = !m_last_dm;
                    e_if_gnt = m_last_dm;
                end else begin
                    e_if_gnt = if_req_i;
                    e_dm_gnt = dm_req_i;
                end
            end
            e_stall = m_busy || (if_req_i && !e_if_gnt) || (dm_req_i && !e_dm_gnt);

            smp();
            chk1 ("rnd.if_gnt", if_gnt_o, e_if_gnt);
            chk1 ("rnd.dm_gnt", dm_gnt_o, e_dm_gnt);
            chk1 ("rnd.stall", stall_o, e_stall);
            chk1 ("rnd.mem_req", mem_req_o, m_busy);
            if (m_busy) begin
                chk32("rnd.mem_addr", mem_addr_o, m_addr);
                chk1 ("rnd.mem_we", mem_we_o, m_we);
                chk32("rnd.mem_wdata", mem_wdata_o, m_wdata);
            end
            chk1 ("rnd.if_rv", if_rvalid_o, m_rv_if);
            chk1 ("rnd.dm_rv", dm_rvalid_o, m_rv_dm);
            chk32("rnd.if_rd", if_rdata_o, m_rd_if);
            chk32("rnd.dm_rd", dm_rdata_o, m_rd_dm);

            m_rv_if = 1'b0; m_rv_dm = 1'b0;
            if (m_busy) begin
                if (mem_ready_i) begin
                    m_busy = 1'b0;
                    if (m_owner_dm) begin
                        m_rv_dm = 1'b1;
                        m_rd_dm = m_we ? 32'h0 : mem_rdata_i;
                    end else begin
                        m_rv_if = 1'b1;
                        m_rd_if = mem_rdata_i;
                    end
                end else begin
                    m_cnt++;
                end
            end else if (e_if_gnt || e_dm_gnt) begin
                m_busy = 1'b1;
                m_cnt = 1;
                m_k = $urandom_range(1, 3);
                m_owner_dm = e_dm_gnt;
                m_last_dm = e_dm_gnt;
                m_addr = e_dm_gnt ? dm_addr_i : if_addr_i;
                m_we = e_dm_gnt && dm_we_i;
                m_wdata = e_dm_gnt ? dm_wdata_i : 32'h0;
            end
            if (e_if_gnt) if_drop = 1'b1;
            if (e_dm_gnt) dm_drop = 1'b1;
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
